// File: rtl/imem_loader_pkg.sv
// Shared loader types: FSM state encoding and frame-format constants.
package loader_pkg;
  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam int HDR_W          = 16;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus the core's combinational fetch port.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (output rx_valid, rx_data, imem_addr, input rx_ready, imem_data);
  modport slave  (input rx_valid, rx_data, imem_addr, output rx_ready, imem_data);
endinterface

// File: rtl/imem_loader_ram.sv
// Word-addressed instruction RAM: synchronous write, asynchronous read (old data on same-cycle read/write).
module imem_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/XOR-checksum byte frame into the instruction RAM,
// holding the core in reset until a good load, then serves combinational fetches.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  output logic          core_reset,
  output logic          load_done,
  output logic          load_error
);
  state_t                state, state_nxt;
  logic [HDR_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            csum_q, csum_d;
  logic                  accept;
  logic                  we;
  logic [31:0]           wdata;
  logic [HDR_W-1:0]      len_full;
  logic                  last_word;
  logic [31:0]           ram_rdata;
  logic                  addr_oob;

  assign bus.rx_ready = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA)   || (state == CSUM);
  assign accept    = bus.rx_valid && bus.rx_ready;
  assign len_full  = {bus.rx_data, len_q[7:0]};
  assign last_word = (HDR_W'(wptr_q) + HDR_W'(1)) == len_q;

  always_comb begin
    state_nxt = state;
    len_d     = len_q;
    wptr_d    = wptr_q;
    bidx_d    = bidx_q;
    asm_d     = asm_q;
    csum_d    = csum_q;
    we        = 1'b0;
    wdata     = {bus.rx_data, asm_q};
    case (state)
      LEN_LO: if (accept) begin
        len_d     = {8'h00, bus.rx_data};
        state_nxt = LEN_HI;
      end
      LEN_HI: if (accept) begin
        len_d  = len_full;
        wptr_d = '0;
        bidx_d = '0;
        csum_d = '0;
        if (32'(len_full) > 32'(DEPTH))  state_nxt = ERROR;
        else if (len_full == '0)         state_nxt = CSUM;
        else                             state_nxt = DATA;
      end
      DATA: if (accept) begin
        // Little-endian assembly: the newest byte enters at the top.
        csum_d = csum_q ^ bus.rx_data;
        asm_d  = {bus.rx_data, asm_q[23:8]};
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'(BYTES_PER_WORD - 1)) begin
          we = 1'b1;
          if (last_word) state_nxt = CSUM;
          else           wptr_d    = wptr_q + ADDR_WIDTH'(1);
        end
      end
      CSUM: if (accept) begin
        state_nxt = (bus.rx_data == csum_q) ? RUN : ERROR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LEN_LO;
      len_q      <= '0;
      wptr_q     <= '0;
      bidx_q     <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      len_q      <= len_d;
      wptr_q     <= wptr_d;
      bidx_q     <= bidx_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      core_reset <= (state_nxt != RUN);
      load_done  <= (state_nxt == RUN);
      load_error <= (state_nxt == ERROR);
    end
  end

  imem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (bus.imem_addr[ADDR_WIDTH+1:2]),
    .rdata (ram_rdata)
  );

  // Fetches beyond the RAM's byte range read as zero rather than aliasing.
  assign addr_oob      = |(bus.imem_addr >> (ADDR_WIDTH + 2));
  assign bus.imem_data = addr_oob ? 32'h0000_0000 : ram_rdata;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a frame-level reference model and per-cycle status compare.
module tb_imem_loader;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic core_reset, load_done, load_error;

  imem_loader_if bus();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: bytes accepted in the current frame, expected RAM image, expected status.
  int          q[$];
  int          frame[$];
  logic [31:0] mem_m [DEPTH];
  bit          wr_m  [DEPTH];
  bit          in_reset = 1'b1;
  bit          m_rdy = 1'b1, m_cr = 1'b1, m_dn = 1'b0, m_er = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Status as a function of the frame prefix received so far.
  task automatic model_status();
    int n, len, need, x;
    m_rdy = 1; m_cr = 1; m_dn = 0; m_er = 0;
    n = q.size();
    if (n < 2) return;
    len = q[0] | (q[1] << 8);
    if (len > DEPTH) begin m_rdy = 0; m_er = 1; return; end
    need = 2 + 4 * len + 1;
    if (n < need) return;
    x = 0;
    for (int i = 2; i < need - 1; i++) x ^= q[i];
    m_rdy = 0;
    if (x == q[need-1]) begin m_cr = 0; m_dn = 1; end
    else m_er = 1;
  endtask

  task automatic model_push(input int b);
    int n, len, k;
    q.push_back(b);
    n = q.size();
    if (n > 2) begin
      len = q[0] | (q[1] << 8);
      if (len <= DEPTH && (n - 2) % 4 == 0 && (n - 2) / 4 <= len) begin
        k = (n - 2) / 4 - 1;
        mem_m[k] = {8'(q[n-1]), 8'(q[n-2]), 8'(q[n-3]), 8'(q[n-4])};
        wr_m[k]  = 1'b1;
      end
    end
    model_status();
  endtask

  always @(negedge clk) begin
    if (in_reset) begin
      check("rst_core_reset", {31'd0, core_reset}, 32'd1);
      check("rst_load_done",  {31'd0, load_done},  32'd0);
      check("rst_load_error", {31'd0, load_error}, 32'd0);
    end else begin
      check("cyc_rx_ready",   {31'd0, bus.rx_ready}, {31'd0, m_rdy});
      check("cyc_core_reset", {31'd0, core_reset},   {31'd0, m_cr});
      check("cyc_load_done",  {31'd0, load_done},    {31'd0, m_dn});
      check("cyc_load_error", {31'd0, load_error},   {31'd0, m_er});
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_reset = 1'b1; bus.rx_valid = 1'b0;
    q.delete();
    model_status();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_reset = 1'b0;
  endtask

  task automatic send_frame(input int max_gap, input int limit);
    bit rdy;
    @(posedge clk); #1;
    for (int i = 0; i < frame.size() && i < limit; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'(frame[i]);
      @(negedge clk); rdy = bus.rx_ready;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      if (!rdy) break;
      model_push(frame[i]);
    end
  endtask

  task automatic make_frame(input int n, input bit bad);
    logic [31:0] w;
    int x;
    frame.delete();
    frame.push_back(n & 255);
    frame.push_back((n >> 8) & 255);
    x = 0;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++) begin
        frame.push_back(int'(w[8*j +: 8]));
        x ^= int'(w[8*j +: 8]);
      end
    end
    frame.push_back(bad ? (x ^ int'($urandom_range(1, 255))) : x);
  endtask

  task automatic nominal_frame(input int csum);
    frame = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00, 8'h31};
    frame[10] = csum;
  endtask

  task automatic fetch(input logic [31:0] addr, input string name, input logic [31:0] exp);
    bus.imem_addr = addr;
    #1;
    check(name, bus.imem_data, exp);
  endtask

  task automatic check_mem(input int k);
    if (wr_m[k]) fetch(32'(k * 4 + $urandom_range(0, 3)), "mem_word", mem_m[k]);
  endtask

  task automatic check_status(input string name, input bit rdy, input bit cr, input bit dn, input bit er);
    check({name, "_rx_ready"},   {31'd0, bus.rx_ready}, {31'd0, rdy});
    check({name, "_core_reset"}, {31'd0, core_reset},   {31'd0, cr});
    check({name, "_load_done"},  {31'd0, load_done},    {31'd0, dn});
    check({name, "_load_error"}, {31'd0, load_error},   {31'd0, er});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.imem_addr = 32'h0;
    for (int i = 0; i < DEPTH; i++) wr_m[i] = 1'b0;
    do_reset();
    @(negedge clk);
    check_status("reset", 1, 1, 0, 0);

    // Nominal two-word load
    nominal_frame(8'h31);
    send_frame(0, 1000);
    check_status("nominal", 0, 0, 1, 0);
    fetch(32'd0, "nominal_w0", 32'hDEADBEEF);
    fetch(32'd4, "nominal_w1", 32'h00000013);
    fetch(32'd7, "nominal_w1_lowbits", 32'h00000013);
    fetch(32'h0000_1000, "oob_1000", 32'h0);
    fetch(32'h8000_0004, "oob_msb", 32'h0);

    do_reset();
    nominal_frame(8'h30);
    send_frame(0, 1000);
    check_status("badcsum", 0, 1, 0, 1);

    do_reset();
    frame = '{0, 0, 0};
    send_frame(0, 1000);
    check_status("zero_len", 0, 0, 1, 0);
    do_reset();
    frame = '{0, 0, 1};
    send_frame(0, 1000);
    check_status("zero_len_bad", 0, 1, 0, 1);

    do_reset();
    frame = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_frame(0, 2);
    check_status("overflow", 0, 1, 0, 1);

    // Exact-fill load: every word of the RAM
    do_reset();
    make_frame(DEPTH, 0);
    send_frame(0, 100000);
    check_status("full", 0, 0, 1, 0);
    check_mem(0);
    check_mem(DEPTH - 1);
    for (int i = 0; i < 20; i++) check_mem($urandom_range(0, DEPTH - 1));

    do_reset();
    nominal_frame(8'h31);
    send_frame(4, 1000);
    check_status("gaps", 0, 0, 1, 0);
    fetch(32'd1, "gaps_w0", 32'hDEADBEEF);
    fetch(32'd6, "gaps_w1", 32'h00000013);

    // Abort after five bytes, then a clean frame
    do_reset();
    nominal_frame(8'h31);
    send_frame(0, 5);
    do_reset();
    send_frame(2, 1000);
    check_status("midreset", 0, 0, 1, 0);
    fetch(32'd0, "midreset_w0", 32'hDEADBEEF);

    for (int t = 0; t < 8; t++) begin
      do_reset();
      n = $urandom_range(0, 24);
      make_frame(n, ($urandom_range(0, 2) == 0));
      send_frame(3, 1000);
      @(negedge clk);
      for (int k = 0; k < n; k++) check_mem(k);
      fetch($urandom | (32'h1 << $urandom_range(AW + 2, 31)), "oob_rand", 32'h0);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
